serial_word_deserializer: RTL
=============================

Name: serial_word_deserializer

Overview:
- Serial-in/parallel-out stage that sits directly downstream of the D flip-flop data-capture stage.
- Consumes the registered serial bit stream (the flip-flop Q output) and assembles it MSB-first into WIDTH-bit words.
- Presents each completed word with a one-cycle VALID strobe for the next stage.
- A frame-start handshake and a shift enable allow sparse or gapped bit streams.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.

Ports:
- CLK  input  1  rising-edge clock.
- CLR  input  1  asynchronous, active-high reset; clears all state immediately.
- START  input  1  frame-start request; sampled only in IDLE or DONE.
- EN  input  1  shift enable; a bit is sampled only on edges where EN=1 and the FSM is in SHIFT or PARITY.
- SER_IN  input  1  serial data bit (driven by the upstream flip-flop Q).
- PAR_OUT  output  WIDTH  last completed word; holds between words.
- VALID  output  1  high for exactly one cycle when PAR_OUT updates.
- BUSY  output  1  high while in SHIFT or PARITY.
- PAR_ERR  output  1  parity error flag for the word on PAR_OUT (see Optional Feature).

Behaviour:
- Interface: one clock, CLK; reset is asynchronous and active-high, CLR.
- Reset values, applied while CLR=1 regardless of CLK:
  - state=IDLE, shift register=0, bit counter=0.
  - PAR_OUT=0, VALID=0, BUSY=0, PAR_ERR=0.
- FSM states: IDLE, SHIFT, PARITY (present only with the macro), DONE. All outputs are registered.
- IDLE:
  - START=1 -> SHIFT with counter=0. SER_IN is not sampled on this edge.
  - START=0 -> stay in IDLE.
- SHIFT:
  - Edge with EN=1: sr <= {sr[WIDTH-2:0], SER_IN}; counter increments.
  - Edge with EN=0: shift register and counter hold; no timeout.
  - START is ignored in SHIFT.
- Last data bit (EN=1 while counter==WIDTH-1):
  - Without the macro: PAR_OUT <= {sr[WIDTH-2:0], SER_IN} on that same edge; next state DONE.
  - With the macro: next state PARITY.
- DONE:
  - VALID=1 for this single cycle; BUSY=0.
  - START=1 -> SHIFT directly, allowing back-to-back frames with no IDLE gap.
  - START=0 -> IDLE.
- Latency: VALID rises on the clock edge on which the final bit (data or parity) is sampled, and falls one cycle later.
- Counter width is clog2(WIDTH)+1 bits and never wraps. It is cleared on every entry to SHIFT.
- PAR_OUT and PAR_ERR change only on a word-completion edge or on reset.
- CLR asserted mid-frame: the partial word is discarded and PAR_OUT returns to 0. After CLR falls, a new START is required.
- SER_IN is ignored in IDLE and DONE.

Optional Feature:
- Macro: DESER_PARITY_CHECK_EN.
- Defined:
  - After WIDTH data bits, the FSM enters PARITY and samples one further bit on the next EN=1 edge. EN=0 holds the FSM in PARITY.
  - On that edge: PAR_OUT <= data word; PAR_ERR <= (^data) ^ parity_bit, so even parity is expected; state -> DONE.
- Undefined:
  - The PARITY state does not exist.
  - The PAR_ERR port remains but is tied to constant 0.
  - The frame is exactly WIDTH bits.

Test Plan:
- Basic frame: WIDTH=8, reset then CLR=0, START pulse, then bits 1,0,1,0,0,1,0,1 with EN=1 -> PAR_OUT=0xA5, VALID high one cycle on the 8th bit edge, BUSY low afterwards.
- EN gaps: same frame with EN=0 for 2 cycles after bit 3 and after bit 6 -> PAR_OUT=0xA5; VALID delayed exactly 4 cycles; no extra bits captured.
- Back-to-back: START held high in DONE, then frame 0x3C -> PAR_OUT=0x3C with no IDLE cycle between the two VALID pulses (pulses are 9 cycles apart).
- Mid-frame reset: CLR pulsed after bit 5 of 0xFF -> PAR_OUT=0, BUSY=0, VALID=0 immediately. Frame 0x81 after a new START -> PAR_OUT=0x81.
- START ignored in SHIFT: START asserted during bits 2-4 of 0x5A -> single VALID with PAR_OUT=0x5A; BUSY never drops mid-frame.
- Parity (macro defined): 0xA5 followed by parity 0 -> PAR_ERR=0; 0xA5 followed by parity 1 -> PAR_ERR=1. In both cases VALID occurs on the 9th sampled bit.

Source files
------------

// File: rtl/serial_word_deserializer_if.sv
// ---------------------------------------------------------------------------
// serial_word_deserializer_if
//   Bundles the bit-stream inputs and word outputs of serial_word_deserializer.
//   master : the side that feeds bits and consumes words (upstream/test side)
//   slave  : the deserializer itself
// Signals:
//   start   frame-start request
//   en      shift enable (qualifies ser_in)
//   ser_in  serial data bit, MSB first
//   par_out last completed word
//   valid   one-cycle strobe when par_out updates
//   busy    high while a frame is being shifted in
//   par_err parity error flag for the word on par_out
// ---------------------------------------------------------------------------
interface serial_word_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             en;
    logic             ser_in;
    logic [WIDTH-1:0] par_out;
    logic             valid;
    logic             busy;
    logic             par_err;

    modport master (
        output start, en, ser_in,
        input  par_out, valid, busy, par_err
    );

    modport slave (
        input  start, en, ser_in,
        output par_out, valid, busy, par_err
    );
endinterface

// File: rtl/serial_word_deserializer.sv
// ---------------------------------------------------------------------------
// serial_word_deserializer
//   Serial-in / parallel-out stage. Assembles an MSB-first bit stream into
//   WIDTH-bit words and presents each completed word with a one-cycle valid.
//   Bits are taken only on edges with en=1, so gapped streams are allowed.
//
// Ports:
//   i_clk   rising-edge clock
//   i_clr   asynchronous active-high clear of all state
//   if_bus  serial_word_deserializer_if.slave (start/en/ser_in in,
//           par_out/valid/busy/par_err out)
//
// Optional feature macro: DESER_PARITY_CHECK_EN
//   Defined  : one extra (even) parity bit follows the data bits; par_err
//              reports (^data) ^ parity for the completed word.
//   Undefined: frame is exactly WIDTH bits and par_err is constant 0.
// ---------------------------------------------------------------------------
module serial_word_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_clr,
    serial_word_deserializer_if.slave    if_bus
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef DESER_PARITY_CHECK_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_DONE   = 2'd3
    } state_t;
    // Whole data word must be held while waiting for the parity bit.
    localparam int SRW = WIDTH;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd3
    } state_t;
    // The last data bit goes straight into par_out, so only WIDTH-1 bits
    // ever need to be stored.
    localparam int SRW = WIDTH - 1;
`endif

    state_t           r_state, w_state_next;
    logic [SRW-1:0]   r_sr, w_sr_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic [WIDTH-1:0] r_par_out, w_par_out_next;
    logic             r_valid, w_valid_next;
    logic             r_busy, w_busy_next;
    logic [WIDTH-1:0] w_shift;

`ifdef DESER_PARITY_CHECK_EN
    logic             r_par_err, w_par_err_next;
    assign w_shift = {r_sr[WIDTH-2:0], if_bus.ser_in};
`else
    assign w_shift = {r_sr, if_bus.ser_in};
`endif

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_state   <= S_IDLE;
            r_sr      <= '0;
            r_cnt     <= '0;
            r_par_out <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_sr      <= w_sr_next;
            r_cnt     <= w_cnt_next;
            r_par_out <= w_par_out_next;
            r_valid   <= w_valid_next;
            r_busy    <= w_busy_next;
        end
    end

`ifdef DESER_PARITY_CHECK_EN
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_par_err_next;
        end
    end
`endif

    always_comb begin
        w_state_next   = r_state;
        w_sr_next      = r_sr;
        w_cnt_next     = r_cnt;
        w_par_out_next = r_par_out;
`ifdef DESER_PARITY_CHECK_EN
        w_par_err_next = r_par_err;
`endif
        case (r_state)
            S_IDLE: begin
                if (if_bus.start) begin
                    w_state_next = S_SHIFT;
                    w_cnt_next   = '0;
                end
            end
            S_SHIFT: begin
                if (if_bus.en) begin
                    w_cnt_next = r_cnt + CW'(1);
`ifdef DESER_PARITY_CHECK_EN
                    w_sr_next  = w_shift;
                    if (r_cnt == LAST_BIT) begin
                        w_state_next = S_PARITY;
                    end
`else
                    w_sr_next  = w_shift[SRW-1:0];
                    if (r_cnt == LAST_BIT) begin
                        w_par_out_next = w_shift;
                        w_state_next   = S_DONE;
                    end
`endif
                end
            end
`ifdef DESER_PARITY_CHECK_EN
            S_PARITY: begin
                if (if_bus.en) begin
                    w_par_out_next = r_sr;
                    // Even parity: a correct parity bit makes the XOR zero.
                    w_par_err_next = (^r_sr) ^ if_bus.ser_in;
                    w_state_next   = S_DONE;
                end
            end
`endif
            S_DONE: begin
                // START here chains the next frame without an IDLE gap.
                if (if_bus.start) begin
                    w_state_next = S_SHIFT;
                    w_cnt_next   = '0;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // DONE never lasts more than one cycle, so entering it is the strobe.
        w_valid_next = (w_state_next == S_DONE);
`ifdef DESER_PARITY_CHECK_EN
        w_busy_next  = (w_state_next == S_SHIFT) || (w_state_next == S_PARITY);
`else
        w_busy_next  = (w_state_next == S_SHIFT);
`endif
    end

    assign if_bus.par_out = r_par_out;
    assign if_bus.valid   = r_valid;
    assign if_bus.busy    = r_busy;
`ifdef DESER_PARITY_CHECK_EN
    assign if_bus.par_err = r_par_err;
`else
    assign if_bus.par_err = 1'b0;
`endif

endmodule
